hs32_pipectl: RTL and testbench
===============================

HS32_PIPECTL -- requirements
Module: hs32_pipectl

Interface
REQ-001 SHALL have parameter RESET_VEC, default 32'h0000_0000, PC loaded after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port br_req  input  1  exec branch taken, single-cycle pulse.
REQ-005 SHALL have port br_pc  input  32  branch target, valid with br_req.
REQ-006 SHALL have port exec_busy  input  1  exec mid-instruction, including an outstanding memory access.
REQ-007 SHALL have port fetch_idle  input  1  fetch has no outstanding memory request.
REQ-008 SHALL have port dec_valid  input  1  decode holds a valid instruction for exec.
REQ-009 SHALL have port irq_req  input  1  level interrupt request.
REQ-010 SHALL have port irq_vec  input  32  handler address, valid with irq_req.
REQ-011 SHALL have port irq_ack  output  1  one-cycle pulse, interrupt taken.
REQ-012 SHALL have port newpc  output  32  fetch restart address, valid while flush=1.
REQ-013 SHALL have port flush  output  1  one-cycle pulse, fetch discards queue and restarts at newpc.
REQ-014 SHALL have port hold  output  1  decode/exec squash; no instruction issues while high.
REQ-015 SHALL have port flush_cnt  output  16  saturating count of flush pulses.

Function
REQ-016 SHALL implement states BOOT, RUN, IRQ_WAIT, DRAIN, REFILL; flush, newpc, irq_ack registered; hold = (state != RUN), decoded from state register.
REQ-017 BOOT: next cycle flush<=1, newpc<=RESET_VEC, state<=DRAIN.
REQ-018 RUN, br_req=1: flush<=1, newpc<=br_pc, state<=DRAIN; br_req has priority over irq_req in the same cycle.
REQ-019 RUN, br_req=0, irq_req=1, exec_busy=0: flush<=1, newpc<=irq_vec, irq_ack<=1, state<=DRAIN.
REQ-020 RUN, br_req=0, irq_req=1, exec_busy=1: state<=IRQ_WAIT.
REQ-021 IRQ_WAIT: br_req=1 takes branch per REQ-018; else irq_req=0 returns to RUN; else exec_busy=0 takes interrupt per REQ-019.
REQ-022 flush and irq_ack SHALL be high only in the first DRAIN cycle; irq_ack never high without flush.
REQ-023 DRAIN: exit to REFILL when fetch_idle=1 and flush=0; minimum DRAIN residency is 2 cycles.
REQ-024 DRAIN/REFILL: br_req and irq_req ignored; the instruction is squashed, and irq remains pending while the level is held.
REQ-025 REFILL: dec_valid=1 -> RUN; hold deasserts the following cycle.
REQ-026 newpc SHALL hold its last value when flush=0.
REQ-027 flush_cnt SHALL increment on every flush pulse, including BOOT, and saturate at 16'hFFFF.

Reset
REQ-028 reset=1 SHALL set state=BOOT, flush=0, irq_ack=0, newpc=0, flush_cnt=0, hold=1 on the next edge.
REQ-029 reset asserted in any state, including mid-DRAIN, SHALL abandon the operation with no further flush until BOOT completes.

Configuration
REQ-030 Macro HS32_PIPECTL_IRQ_EN defined: interrupt behaviour per REQ-019..021.
REQ-031 Macro HS32_PIPECTL_IRQ_EN undefined: irq_req/irq_vec ignored, IRQ_WAIT unreachable, irq_ack constant 0.

Verification
REQ-032 Reset 2 cycles, RESET_VEC=32'h100 -> flush pulse with newpc=32'h100, flush_cnt=1, hold high until dec_valid.
REQ-033 RUN, br_req with br_pc=32'h2000 -> next cycle flush=1, newpc=32'h2000; fetch_idle low 3 cycles -> DRAIN held; then REFILL -> RUN after dec_valid.
REQ-034 RUN, br_req=1 and irq_req=1 (irq_vec=32'h40) same cycle -> branch taken, irq_ack=0; irq then taken after REFILL completes with newpc=32'h40 and irq_ack=1.
REQ-035 irq_req=1 with exec_busy=1 for 4 cycles -> IRQ_WAIT, hold=1, no flush; exec_busy falls -> flush+irq_ack with newpc=irq_vec.
REQ-036 Reset asserted during DRAIN -> BOOT, flush_cnt=0; 70000 branches -> flush_cnt stays 16'hFFFF.
REQ-037 Build without HS32_PIPECTL_IRQ_EN, irq_req held high -> irq_ack never asserts, state never IRQ_WAIT.

Source files
------------

// File: rtl/hs32_pipectl_if.sv
// Pipeline-control bundle between the controller and the fetch/decode/exec stages.
// master = controller side, slave = pipeline side.
interface hs32_pipectl_if;
    logic        br_req;
    logic [31:0] br_pc;
    logic        exec_busy;
    logic        fetch_idle;
    logic        dec_valid;
    logic        irq_req;
    logic [31:0] irq_vec;
    logic        irq_ack;
    logic [31:0] newpc;
    logic        flush;
    logic        hold;
    logic [15:0] flush_cnt;

    modport master (
        input  br_req, br_pc, exec_busy, fetch_idle, dec_valid, irq_req, irq_vec,
        output irq_ack, newpc, flush, hold, flush_cnt
    );

    modport slave (
        output br_req, br_pc, exec_busy, fetch_idle, dec_valid, irq_req, irq_vec,
        input  irq_ack, newpc, flush, hold, flush_cnt
    );
endinterface

// File: rtl/hs32_pipectl.sv
// Purpose: HS32 fetch-restart controller (boot, branch, interrupt); interrupts enabled by HS32_PIPECTL_IRQ_EN.
// Latency: flush/newpc/irq_ack registered, one cycle after the triggering event.
// Backpressure: hold stalls issue outside RUN; drain waits for fetch_idle, refill waits for dec_valid.
module hs32_pipectl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    hs32_pipectl_if.master  p
);

    typedef enum logic [2:0] {
        BOOT     = 3'd0,
        RUN      = 3'd1,
        IRQ_WAIT = 3'd2,
        DRAIN    = 3'd3,
        REFILL   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        flush_q, flush_d;
    logic        irq_ack_q, irq_ack_d;
    logic [31:0] newpc_q, newpc_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    logic        irq_pend;
    logic [31:0] irq_target;

`ifdef HS32_PIPECTL_IRQ_EN
    assign irq_pend   = p.irq_req;
    assign irq_target = p.irq_vec;
`else
    // Interrupt inputs are deliberately dropped; IRQ_WAIT can never be entered.
    logic unused_irq;
    assign unused_irq = ^{p.irq_req, p.irq_vec};
    assign irq_pend   = 1'b0;
    assign irq_target = 32'h0000_0000;
`endif

    always_comb begin
        state_d   = state_q;
        flush_d   = 1'b0;
        irq_ack_d = 1'b0;
        newpc_d   = newpc_q;

        case (state_q)
            BOOT: begin
                flush_d = 1'b1;
                newpc_d = RESET_VEC;
                state_d = DRAIN;
            end
            RUN, IRQ_WAIT: begin
                // Branch wins over a simultaneous interrupt; the irq level stays pending.
                if (p.br_req) begin
                    flush_d = 1'b1;
                    newpc_d = p.br_pc;
                    state_d = DRAIN;
                end else if (irq_pend && !p.exec_busy) begin
                    flush_d   = 1'b1;
                    irq_ack_d = 1'b1;
                    newpc_d   = irq_target;
                    state_d   = DRAIN;
                end else if (irq_pend) begin
                    state_d = IRQ_WAIT;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                // flush_q is high only on the first DRAIN cycle, giving two cycles minimum.
                if (p.fetch_idle && !flush_q) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (p.dec_valid) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        flush_cnt_d = (flush_d && (flush_cnt_q != 16'hFFFF)) ? flush_cnt_q + 16'd1
                                                             : flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= BOOT;
            flush_q     <= 1'b0;
            irq_ack_q   <= 1'b0;
            newpc_q     <= 32'h0000_0000;
            flush_cnt_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            flush_q     <= flush_d;
            irq_ack_q   <= irq_ack_d;
            newpc_q     <= newpc_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign p.flush     = flush_q;
    assign p.irq_ack   = irq_ack_q;
    assign p.newpc     = newpc_q;
    assign p.flush_cnt = flush_cnt_q;
    assign p.hold      = (state_q != RUN);

endmodule

// File: tb/tb_hs32_pipectl.sv
// Directed + randomized bench for hs32_pipectl against a restart-sequence reference model.
module tb_hs32_pipectl;

    localparam logic [31:0] RV = 32'h0000_0100;
`ifdef HS32_PIPECTL_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    hs32_pipectl_if ifc();

    hs32_pipectl #(.RESET_VEC(RV)) dut (
        .clk   (clk),
        .reset (reset),
        .p     (ifc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: tracks "boot pending", "restart in progress" and "waiting for exec".
    bit          m_boot, m_restart, m_fetch_done, m_irq_wait;
    logic        m_flush, m_ack, m_hold;
    logic [31:0] m_newpc;
    logic [15:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic        f, a;
        logic [31:0] tgt;
        if (reset) begin
            m_boot = 1; m_restart = 0; m_fetch_done = 0; m_irq_wait = 0;
            m_flush = 0; m_ack = 0; m_newpc = 32'h0; m_cnt = 16'h0;
        end else begin
            f = 0; a = 0; tgt = m_newpc;
            if (m_boot) begin
                f = 1; tgt = RV; m_boot = 0;
            end else if (m_restart) begin
                if (!m_fetch_done) begin
                    if (ifc.fetch_idle && !m_flush) m_fetch_done = 1;
                end else if (ifc.dec_valid) begin
                    m_restart = 0;
                end
            end else if (ifc.br_req) begin
                f = 1; tgt = ifc.br_pc;
            end else if (IRQ_EN && ifc.irq_req) begin
                if (!ifc.exec_busy) begin
                    f = 1; a = 1; tgt = ifc.irq_vec;
                end else begin
                    m_irq_wait = 1;
                end
            end else begin
                m_irq_wait = 0;
            end
            if (f) begin
                m_restart = 1; m_fetch_done = 0; m_irq_wait = 0;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
            m_flush = f; m_ack = a; m_newpc = tgt;
        end
        m_hold = m_boot || m_restart || m_irq_wait;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("flush",     {31'b0, ifc.flush},   {31'b0, m_flush});
        chk("irq_ack",   {31'b0, ifc.irq_ack}, {31'b0, m_ack});
        chk("hold",      {31'b0, ifc.hold},    {31'b0, m_hold});
        chk("newpc",     ifc.newpc,            m_newpc);
        chk("flush_cnt", {16'b0, ifc.flush_cnt}, {16'b0, m_cnt});
    endtask

    task automatic drive(input logic br, input logic [31:0] pc, input logic busy,
                         input logic idle, input logic dv, input logic irq,
                         input logic [31:0] vec);
        ifc.br_req = br; ifc.br_pc = pc; ifc.exec_busy = busy; ifc.fetch_idle = idle;
        ifc.dec_valid = dv; ifc.irq_req = irq; ifc.irq_vec = vec;
    endtask

    initial begin
        drive(0, 32'h0, 0, 1, 0, 0, 32'h0);
        reset = 1'b1;
        cyc();
        cyc();
        chk("rst_flush", {31'b0, ifc.flush}, 32'd0);
        chk("rst_hold",  {31'b0, ifc.hold},  32'd1);
        chk("rst_cnt",   {16'b0, ifc.flush_cnt}, 32'd0);
        chk("rst_newpc", ifc.newpc, 32'h0);

        // Boot restart to RESET_VEC, hold until decode delivers.
        reset = 1'b0;
        cyc();
        chk("boot_flush", {31'b0, ifc.flush}, 32'd1);
        chk("boot_newpc", ifc.newpc, 32'h100);
        chk("boot_cnt",   {16'b0, ifc.flush_cnt}, 32'd1);
        cyc();
        cyc();
        cyc();
        chk("boot_hold_wait_dv", {31'b0, ifc.hold}, 32'd1);
        ifc.dec_valid = 1'b1;
        cyc();
        chk("boot_run", {31'b0, ifc.hold}, 32'd0);

        // Branch with slow fetch drain.
        drive(1, 32'h2000, 0, 0, 1, 0, 32'h0);
        cyc();
        chk("br_flush", {31'b0, ifc.flush}, 32'd1);
        chk("br_newpc", ifc.newpc, 32'h2000);
        ifc.br_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("br_drain_hold", {31'b0, ifc.hold}, 32'd1);
        end
        ifc.fetch_idle = 1'b1;
        cyc();
        cyc();
        chk("br_back_run", {31'b0, ifc.hold}, 32'd0);
        chk("br_newpc_kept", ifc.newpc, 32'h2000);

        // Branch and interrupt in the same cycle: branch wins, irq follows after refill.
        drive(1, 32'h3000, 0, 1, 1, 1, 32'h40);
        cyc();
        chk("brirq_newpc", ifc.newpc, 32'h3000);
        chk("brirq_ack",   {31'b0, ifc.irq_ack}, 32'd0);
        ifc.br_req = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("brirq_run", {31'b0, ifc.hold}, 32'd0);
        cyc();
`ifdef HS32_PIPECTL_IRQ_EN
        chk("irq_after_flush", {31'b0, ifc.flush}, 32'd1);
        chk("irq_after_newpc", ifc.newpc, 32'h40);
        chk("irq_after_ack",   {31'b0, ifc.irq_ack}, 32'd1);
`else
        chk("noirq_ack",  {31'b0, ifc.irq_ack}, 32'd0);
        chk("noirq_hold", {31'b0, ifc.hold}, 32'd0);
`endif
        ifc.irq_req = 1'b0;
        for (int i = 0; i < 4; i++) cyc();

        // Interrupt held off by a busy exec stage.
        drive(0, 32'h0, 1, 1, 1, 1, 32'h80);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("busy_noflush", {31'b0, ifc.flush}, 32'd0);
            chk("busy_hold",    {31'b0, ifc.hold},  {31'b0, IRQ_EN});
            chk("busy_noack",   {31'b0, ifc.irq_ack}, 32'd0);
        end
        ifc.exec_busy = 1'b0;
        cyc();
        chk("busy_rel_flush", {31'b0, ifc.flush},   {31'b0, IRQ_EN});
        chk("busy_rel_ack",   {31'b0, ifc.irq_ack}, {31'b0, IRQ_EN});
        ifc.irq_req = 1'b0;
        for (int i = 0; i < 4; i++) cyc();

        // Flush counter saturation, preloaded near the top to keep the run short.
        force dut.flush_cnt_q = 16'hFFF0;
        #1;
        release dut.flush_cnt_q;
        m_cnt = 16'hFFF0;
        drive(1, 32'h5000, 0, 1, 1, 0, 32'h0);
        for (int i = 0; i < 100; i++) cyc();
        chk("cnt_saturated", {16'b0, ifc.flush_cnt}, 32'h0000_FFFF);
        ifc.br_req = 1'b0;
        for (int i = 0; i < 4; i++) cyc();

        // Reset in the middle of a drain.
        drive(1, 32'h6000, 0, 0, 1, 0, 32'h0);
        cyc();
        ifc.br_req = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        chk("midrst_cnt",   {16'b0, ifc.flush_cnt}, 32'd0);
        chk("midrst_flush", {31'b0, ifc.flush}, 32'd0);
        chk("midrst_hold",  {31'b0, ifc.hold}, 32'd1);
        cyc();
        reset = 1'b0;
        ifc.fetch_idle = 1'b1;
        cyc();
        chk("midrst_boot_newpc", ifc.newpc, 32'h100);
        chk("midrst_boot_cnt",   {16'b0, ifc.flush_cnt}, 32'd1);

        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 4000; i++) begin
            ifc.br_req     = ($urandom_range(7) == 0);
            ifc.br_pc      = $urandom;
            ifc.exec_busy  = ($urandom_range(1) == 0);
            ifc.fetch_idle = ($urandom_range(2) != 0);
            ifc.dec_valid  = ($urandom_range(1) == 0);
            if ($urandom_range(9) == 0) ifc.irq_req = ~ifc.irq_req;
            ifc.irq_vec    = $urandom;
            reset          = ($urandom_range(199) == 0);
            cyc();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
